// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access from the M register and the W pipeline register.
// A faulted or halted instruction in W freezes W and blocks all later memory writes until rst.
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_stat,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        dmem_error,
    output logic        W_stall,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_stat,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [3:0]  Stat
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] R_NONE = 4'hF;

    logic [7:0]    mem_q [MEM_BYTES];
    logic [7:0]    mem_d [MEM_BYTES];

    logic [3:0]    w_icode_q, w_icode_d;
    logic [3:0]    w_stat_q,  w_stat_d;
    logic [63:0]   w_vale_q,  w_vale_d;
    logic [63:0]   w_valm_q,  w_valm_d;
    logic [3:0]    w_dste_q,  w_dste_d;
    logic [3:0]    w_dstm_q,  w_dstm_d;

    logic          rd_en;
    logic          wr_en;
    logic          wr_commit;
    logic [63:0]   addr;
    logic [AW-1:0] base;
    logic [63:0]   rd_data;

    always_comb begin
        rd_en      = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
        wr_en      = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
        addr       = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
        // Full 64-bit compare so huge addresses cannot alias back into range.
        dmem_error = (rd_en || wr_en) && (addr > 64'(MEM_BYTES - 8));
        base       = addr[AW-1:0];
        rd_data    = '0;
        for (int i = 0; i < 8; i++) begin
            rd_data[8*i +: 8] = mem_q[base + AW'(i)];
        end
        m_valM     = (rd_en && !dmem_error) ? rd_data : 64'h0;
        m_stat     = dmem_error ? S_ADR : M_stat;
    end

    always_comb begin
        W_stall   = (w_stat_q == S_HLT) || (w_stat_q == S_ADR) || (w_stat_q == S_INS);
        wr_commit = wr_en && !dmem_error && (M_stat == S_AOK) && (w_stat_q == S_AOK);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_commit) begin
            for (int i = 0; i < 8; i++) begin
                mem_d[base + AW'(i)] = M_valA[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_icode_d = w_icode_q;
        w_stat_d  = w_stat_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            w_icode_d = M_icode;
            w_stat_d  = m_stat;
            w_vale_d  = M_valE;
            w_valm_d  = m_valM;
            w_dste_d  = M_dstE;
            w_dstm_d  = M_dstM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
            w_icode_q <= I_NOP;
            w_stat_q  <= S_AOK;
            w_vale_q  <= 64'h0;
            w_valm_q  <= 64'h0;
            w_dste_q  <= R_NONE;
            w_dstm_q  <= R_NONE;
        end else begin
            mem_q     <= mem_d;
            w_icode_q <= w_icode_d;
            w_stat_q  <= w_stat_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
        end
    end

    assign W_icode = w_icode_q;
    assign W_stat  = w_stat_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;
    assign Stat    = w_stat_q;

endmodule
